// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stall vector
// layout, stall patterns, bubble/reset polarities and FSM state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    // stall bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved
    localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MC       = 6'b001111;

    localparam logic BBL_ENABLE  = 1'b1;
    localparam logic BBL_DISABLE = 1'b0;
    localparam logic RST_ENABLE  = 1'b0;

    typedef enum logic {
        PC_IDLE    = 1'b0,
        PC_MC_BUSY = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Stateless load-use comparator: flags when the consuming stage reads a
// register that an in-flight load is about to write. Kept separate so a
// later MEM-stage load check can reuse it.
module hazard_detect (
    input  logic       ld_is_load_i,
    input  logic       ld_wreg_i,
    input  logic [4:0] ld_wd_i,
    input  logic       rd1_read_i,
    input  logic [4:0] rd1_addr_i,
    input  logic       rd2_read_i,
    input  logic [4:0] rd2_addr_i,
    output logic       lu_o
);

    logic ld_writes;
    logic rd_match;

    // r0 is hardwired zero, so a load targeting it never creates a hazard
    always_comb begin
        ld_writes = ld_is_load_i & ld_wreg_i & (ld_wd_i != 5'd0);
        rd_match  = (rd1_read_i & (rd1_addr_i == ld_wd_i))
                  | (rd2_read_i & (rd2_addr_i == ld_wd_i));
        lu_o      = ld_writes & rd_match;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline hazard controller: per-stage stall vector, ID/EX bubble,
// IF/ID flush, multi-cycle EX sequencing and a saturating stall counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// PC_IDLE    | no multi-cycle op in flight; load-use and branches handled
// PC_MC_BUSY | multi-cycle EX op running; counter holds remaining cycles
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_reg1_read,
    input  logic [4:0]          id_reg1_addr,
    input  logic                id_reg2_read,
    input  logic [4:0]          id_reg2_addr,
    input  logic [4:0]          ex_wd,
    input  logic                ex_wreg,
    input  logic                ex_is_load,
    input  logic                ex_mc_req,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    input  logic                id_branch_flag,
    output logic [STALL_W-1:0]  stall,
    output logic                bbl,
    output logic                if_flush,
    output logic                ex_mc_done,
    output logic [PERF_W-1:0]   stall_cnt
);

    pc_state_e             state_q, state_d;
    logic [MC_CNT_W-1:0]   counter_q, counter_d;
    logic [PERF_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                  lu;

    hazard_detect u_hazard_detect (
        .ld_is_load_i (ex_is_load),
        .ld_wreg_i    (ex_wreg),
        .ld_wd_i      (ex_wd),
        .rd1_read_i   (id_reg1_read),
        .rd1_addr_i   (id_reg1_addr),
        .rd2_read_i   (id_reg2_read),
        .rd2_addr_i   (id_reg2_addr),
        .lu_o         (lu)
    );

    // Outputs and next state: multi-cycle work outranks load-use, which
    // outranks branch flush; everything is quiet while reset is held.
    always_comb begin
        stall      = STALL_NONE;
        bbl        = BBL_DISABLE;
        if_flush   = 1'b0;
        ex_mc_done = 1'b0;
        state_d    = state_q;
        counter_d  = counter_q;
        if (rst != RST_ENABLE) begin
            case (state_q)
                PC_IDLE: begin
                    if (ex_mc_req) begin
                        stall = STALL_MC;
                        // a zero-length request still occupies EX for one cycle
                        if (ex_mc_cycles <= MC_CNT_W'(1)) begin
                            ex_mc_done = 1'b1;
                        end else begin
                            counter_d = ex_mc_cycles - MC_CNT_W'(1);
                            state_d   = PC_MC_BUSY;
                        end
                    end else if (lu) begin
                        stall = STALL_LOAD_USE;
                        bbl   = BBL_ENABLE;
                    end
                end
                PC_MC_BUSY: begin
                    stall = STALL_MC;
                    if (counter_q == MC_CNT_W'(1)) begin
                        ex_mc_done = 1'b1;
                        counter_d  = '0;
                        state_d    = PC_IDLE;
                    end else begin
                        counter_d = counter_q - MC_CNT_W'(1);
                    end
                end
                default: begin
                    state_d   = PC_IDLE;
                    counter_d = '0;
                end
            endcase
            // a held branch is re-presented and flushed on the release cycle
            if_flush = id_branch_flag & ~stall[1];
        end
    end

    // Stall-cycle performance counter saturates rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall[0] && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= PC_IDLE;
            counter_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver applies stimulus each cycle and
// pushes the reference model's expectation; the monitor pops and compares
// at the falling edge.
module tb_pipe_ctrl;

    typedef struct packed {
        logic       rst;
        logic       r1;
        logic [4:0] a1;
        logic       r2;
        logic [4:0] a2;
        logic [4:0] wd;
        logic       wreg;
        logic       load;
        logic       mc_req;
        logic [5:0] cyc;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic [5:0]  stall;
        logic        bbl;
        logic        flush;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_reg1_read, id_reg2_read;
    logic [4:0]  id_reg1_addr, id_reg2_addr, ex_wd;
    logic        ex_wreg, ex_is_load, ex_mc_req, id_branch_flag;
    logic [5:0]  ex_mc_cycles;
    logic [5:0]  stall;
    logic        bbl, if_flush, ex_mc_done;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t  exp_q[$];
    stim_t prev_s;

    // reference state: stalled cycles still owed to a multi-cycle op after
    // the current one, and the stall-cycle count
    int m_left = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_CNT_W(6), .PERF_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_reg1_read   (id_reg1_read),
        .id_reg1_addr   (id_reg1_addr),
        .id_reg2_read   (id_reg2_read),
        .id_reg2_addr   (id_reg2_addr),
        .ex_wd          (ex_wd),
        .ex_wreg        (ex_wreg),
        .ex_is_load     (ex_is_load),
        .ex_mc_req      (ex_mc_req),
        .ex_mc_cycles   (ex_mc_cycles),
        .id_branch_flag (id_branch_flag),
        .stall          (stall),
        .bbl            (bbl),
        .if_flush       (if_flush),
        .ex_mc_done     (ex_mc_done),
        .stall_cnt      (stall_cnt)
    );

    function automatic exp_t m_eval(stim_t s);
        exp_t e;
        int   n;
        bit   lu;
        e = '0;
        e.cnt = 16'(m_cnt);
        if (!s.rst) return e;
        lu = s.load && s.wreg && (s.wd != 0) &&
             ((s.r1 && s.a1 == s.wd) || (s.r2 && s.a2 == s.wd));
        if (m_left > 0) begin
            e.stall = 6'b001111;
            e.done  = (m_left == 1);
        end else if (s.mc_req) begin
            n = (s.cyc == 0) ? 1 : int'(s.cyc);
            e.stall = 6'b001111;
            e.done  = (n == 1);
        end else if (lu) begin
            e.stall = 6'b000111;
            e.bbl   = 1'b1;
        end
        e.flush = s.br && !e.stall[1];
        return e;
    endfunction

    task automatic m_update(stim_t s);
        exp_t e;
        e = m_eval(s);
        if (!s.rst) begin
            m_left = 0;
            m_cnt  = 0;
            return;
        end
        if (e.stall[0] && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_left > 0) m_left = m_left - 1;
        else if (s.mc_req) m_left = ((s.cyc == 0) ? 1 : int'(s.cyc)) - 1;
    endtask

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t mc_s(int cyc);
        stim_t s;
        s = idle_s();
        s.mc_req = 1'b1;
        s.cyc    = 6'(cyc);
        return s;
    endfunction

    function automatic stim_t lu_s(int wd, bit r2);
        stim_t s;
        s = idle_s();
        s.load = 1'b1;
        s.wreg = 1'b1;
        s.wd   = 5'(wd);
        s.r2   = r2;
        s.a2   = 5'(wd);
        return s;
    endfunction

    // one clock of stimulus: retire last cycle into the model, drive, predict
    task automatic step(stim_t s);
        @(posedge clk);
        #1;
        m_update(prev_s);
        rst            = s.rst;
        id_reg1_read   = s.r1;
        id_reg1_addr   = s.a1;
        id_reg2_read   = s.r2;
        id_reg2_addr   = s.a2;
        ex_wd          = s.wd;
        ex_wreg        = s.wreg;
        ex_is_load     = s.load;
        ex_mc_req      = s.mc_req;
        ex_mc_cycles   = s.cyc;
        id_branch_flag = s.br;
        exp_q.push_back(m_eval(s));
        prev_s = s;
    endtask

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // monitor: compare DUT outputs with the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",      int'(stall),      int'(e.stall));
                chk("bbl",        int'(bbl),        int'(e.bbl));
                chk("if_flush",   int'(if_flush),   int'(e.flush));
                chk("ex_mc_done", int'(ex_mc_done), int'(e.done));
                chk("stall_cnt",  int'(stall_cnt),  int'(e.cnt));
            end
        end
    end

    initial begin
        stim_t s;
        prev_s = '0;
        rst = 1'b0;
        {id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr, ex_wd} = '0;
        {ex_wreg, ex_is_load, ex_mc_req, ex_mc_cycles, id_branch_flag} = '0;

        s = idle_s(); s.rst = 1'b0;
        step(s); step(s);
        step(idle_s());

        // load-use on operand 2, then the two non-hazard variants
        step(lu_s(8, 1'b1));
        step(idle_s());
        step(lu_s(0, 1'b1));
        step(lu_s(8, 1'b0));
        s = lu_s(9, 1'b0); s.r1 = 1'b1; s.a1 = 5'd9;
        step(s);
        s = lu_s(9, 1'b1); s.wreg = 1'b0;
        step(s);

        // multi-cycle of 5 from a clean count, then 0 and 1
        s = idle_s(); s.rst = 1'b0;
        step(s);
        step(mc_s(5));
        repeat (5) step(idle_s());
        step(mc_s(0));
        step(idle_s());
        step(mc_s(1));
        step(idle_s());

        // branch held by load-use, released next cycle
        s = lu_s(8, 1'b1); s.br = 1'b1;
        step(s);
        s = idle_s(); s.br = 1'b1;
        step(s);
        s = idle_s(); s.br = 1'b1; s.mc_req = 1'b1; s.cyc = 6'd1;
        step(s);

        // mc request racing a load-use, then a re-request while busy
        s = lu_s(8, 1'b1); s.mc_req = 1'b1; s.cyc = 6'd2;
        step(s);
        s = lu_s(8, 1'b1); s.mc_req = 1'b1; s.cyc = 6'd7;
        step(s);
        step(idle_s());
        step(idle_s());

        // reset while busy with counter at 3
        step(mc_s(5));
        step(idle_s());
        s = idle_s(); s.rst = 1'b0;
        step(s);
        step(idle_s());
        step(idle_s());

        // randomized traffic biased toward register matches
        for (int i = 0; i < 3000; i++) begin
            s = idle_s();
            s.rst    = ($urandom_range(63) != 0);
            s.r1     = 1'($urandom);
            s.a1     = 5'($urandom_range(3));
            s.r2     = 1'($urandom);
            s.a2     = 5'($urandom_range(3));
            s.wd     = 5'($urandom_range(3));
            s.wreg   = ($urandom_range(3) != 0);
            s.load   = 1'($urandom);
            s.mc_req = ($urandom_range(7) == 0);
            s.cyc    = 6'($urandom_range(7));
            s.br     = ($urandom_range(2) == 0);
            step(s);
        end

        // saturation: stall continuously past 65535 cycles
        s = idle_s(); s.rst = 1'b0;
        step(s);
        repeat (65540) step(mc_s(63));
        step(idle_s());
        step(idle_s());
        s = idle_s(); s.rst = 1'b0;
        step(s);
        step(idle_s());

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline hazard controller. It is the source of the per-stage stall vector, the `bbl` bubble-insert signal consumed by the ID/EX register, and the flush signal for the IF/ID register.
- Detects load-use hazards (ID reads a register that a load in EX is writing).
- Sequences multi-cycle EX operations (mult/div) with a down-counter FSM.
- Squashes the fetched instruction on taken branches.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MC_CNT_W, 6, width of the multi-cycle length input and internal counter
- PERF_W, 16, width of the stall-cycle performance counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-low reset; `RstEnable is 1'b0
- id_reg1_read  in  1  ID reads operand 1
- id_reg1_addr  in  5  ID operand-1 register address
- id_reg2_read  in  1  ID reads operand 2
- id_reg2_addr  in  5  ID operand-2 register address
- ex_wd  in  5  EX destination register
- ex_wreg  in  1  EX writes a register
- ex_is_load  in  1  EX instruction is a load
- ex_mc_req  in  1  EX starts a multi-cycle op this cycle
- ex_mc_cycles  in  MC_CNT_W  total EX cycles of that op
- id_branch_flag  in  1  ID resolved a taken branch/jump
- stall  out  6  hold per stage: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved (always 0)
- bbl  out  1  `BblEnable (1'b1): ID/EX loads NOP on next posedge
- if_flush  out  1  IF/ID loads NOP on next posedge
- ex_mc_done  out  1  pulse in the last cycle of a multi-cycle op
- stall_cnt  out  PERF_W  count of cycles with stall[0]=1

Behaviour:
- State is registered (FSM state, counter, stall_cnt). stall, bbl, if_flush and ex_mc_done are combinational from state and current inputs, valid in the same cycle as the hazard.
- Reset (rst==0 at posedge):
  - state=IDLE, counter=0, stall_cnt=0.
  - While rst is low, stall=0, bbl=0, if_flush=0, ex_mc_done=0 regardless of other inputs.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_is_load & ex_wreg & (ex_wd!=0);
  - (id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd).
- FSM states: IDLE, MC_BUSY.
- IDLE:
  - ex_mc_req with N=ex_mc_cycles:
    - N==0 is treated as 1.
    - stall=6'b001111 this cycle.
    - N==1: ex_mc_done=1, stay in IDLE.
    - N>=2: counter<=N-1, go to MC_BUSY.
  - else lu: stall=6'b000111, bbl=1. This lasts one cycle only; the next cycle the load is in MEM and forwarding covers it.
  - else: stall=0.
- MC_BUSY:
  - stall=6'b001111; bbl=0; ex_mc_req ignored.
  - counter==1: ex_mc_done=1, go to IDLE.
  - otherwise counter<=counter-1.
  - Total stalled cycles = N, counting the request cycle.
- Branch flush: if_flush = id_branch_flag & ~stall[1]. When ID is held, the branch is re-presented and flushed on the release cycle.
- Priority: reset > multi-cycle (request or busy) > load-use > branch. ex_mc_req together with lu gives the MC result with bbl=0.
- stall_cnt increments when stall[0]=1 and saturates at all-ones.
- Reset in MC_BUSY returns to IDLE immediately; no ex_mc_done is issued.

Decomposition:
- Add to the shared defines:
  - `StallBus 5:0
  - stall vector constants `StallNone 6'b000000, `StallLoadUse 6'b000111, `StallMc 6'b001111
  - FSM state encodings `PcIdle, `PcMcBusy
- `BblEnable/`BblDisable and `RstEnable come from the existing defines.
- One natural sub-module: `hazard_detect`, the combinational lu comparator (stateless, reusable for a later MEM-stage load check). Counter and FSM stay in `pipe_ctrl`.

Test Plan:
- Reset low mid-MC_BUSY with counter=3 -> next cycle stall=0, ex_mc_done never pulses, stall_cnt=0.
- Load-use: ex_is_load=1, ex_wreg=1, ex_wd=8, id_reg2_read=1, id_reg2_addr=8 -> one cycle of stall=000111, bbl=1. Repeat with ex_wd=0, or with id_reg2_read=0 -> stall=0, bbl=0.
- Multi-cycle: ex_mc_req=1, ex_mc_cycles=5 -> stall=001111 for exactly 5 cycles, ex_mc_done only in cycle 5, stall_cnt=5. Repeat with cycles=0 and cycles=1 -> 1 cycle each, done in the request cycle.
- Branch during load-use: id_branch_flag=1 with lu -> if_flush=0 that cycle; next cycle (no lu) -> if_flush=1.
- Simultaneous ex_mc_req=1 (cycles=2) and lu -> stall=001111, bbl=0; ex_mc_req re-asserted in MC_BUSY is ignored and the counter is unchanged.
- Saturation: preload stall_cnt via 65535 stalled cycles, then one more -> stall_cnt stays 16'hFFFF.
